// File: rtl/button_conditioner.sv
// button_conditioner
//   Synchronises, debounces and edge-detects raw push-buttons. Each bit is
//   handled independently. It produces a clean level and single-cycle
//   press/release pulses.
//   Optional feature macro: BTN_REPEAT_EN adds hold-to-scroll auto-repeat
//   press pulses.
module button_conditioner #(
   parameter int N_BUTTONS       = 5,
   parameter int DEBOUNCE_CYCLES = 60000,
   parameter int CNT_W           = 16
`ifdef BTN_REPEAT_EN
   ,
   parameter int REPEAT_DELAY    = 3000000,
   parameter int REPEAT_PERIOD   = 1200000
`endif
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [N_BUTTONS-1:0] btn_raw,
   output logic [N_BUTTONS-1:0] btn_level,
   output logic [N_BUTTONS-1:0] btn_press,
   output logic [N_BUTTONS-1:0] btn_release
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

`ifdef BTN_REPEAT_EN
   localparam int RC_W = $clog2(REPEAT_DELAY + 1);
   localparam logic [RC_W-1:0] RC_DELAY  = RC_W'(REPEAT_DELAY - 1);
   localparam logic [RC_W-1:0] RC_PERIOD = RC_W'(REPEAT_PERIOD - 1);
   localparam logic [RC_W-1:0] RC_ONE    = RC_W'(1);
`endif

   // Two-flop synchroniser: the only consumer of the asynchronous pins
   logic [N_BUTTONS-1:0] sync1_q, sync1_d;
   logic [N_BUTTONS-1:0] s_q, s_d;

   // Synchroniser next-state
   always_comb begin
      sync1_d = btn_raw;
      s_d     = sync1_q;
   end

   // Synchroniser registers
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q <= '0;
         s_q     <= '0;
      end else begin
         sync1_q <= sync1_d;
         s_q     <= s_d;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < N_BUTTONS; gi++) begin : g_bit
         logic [CNT_W-1:0] cnt_q, cnt_d;
         logic             level_q, level_d;
         logic             press_q, press_d;
         logic             release_q, release_d;
`ifdef BTN_REPEAT_EN
         logic [RC_W-1:0]  rc_q, rc_d;
`endif

         // Debounce counter, accepted level, edge pulses (and auto-repeat)
         always_comb begin
            cnt_d     = cnt_q;
            level_d   = level_q;
            press_d   = 1'b0;
            release_d = 1'b0;
`ifdef BTN_REPEAT_EN
            rc_d      = rc_q;
`endif
            if (s_q[gi] == level_q) begin
               // Any agreeing cycle restarts the stability count
               cnt_d = '0;
            end else if (cnt_q == CNT_MAX) begin
               level_d   = s_q[gi];
               cnt_d     = '0;
               press_d   = s_q[gi];
               release_d = ~s_q[gi];
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
`ifdef BTN_REPEAT_EN
            // Repeat only while held on both sides of this edge, so a
            // repeat pulse can never coincide with a release pulse
            if (!level_d) begin
               rc_d = '0;
            end else if (!level_q) begin
               rc_d = RC_DELAY;
            end else if (rc_q == '0) begin
               press_d = 1'b1;
               rc_d    = RC_PERIOD;
            end else begin
               rc_d = rc_q - RC_ONE;
            end
`endif
         end

         // Per-bit state registers; reset drops level without a release pulse
         always_ff @(posedge clk) begin
            if (reset) begin
               cnt_q     <= '0;
               level_q   <= 1'b0;
               press_q   <= 1'b0;
               release_q <= 1'b0;
`ifdef BTN_REPEAT_EN
               rc_q      <= '0;
`endif
            end else begin
               cnt_q     <= cnt_d;
               level_q   <= level_d;
               press_q   <= press_d;
               release_q <= release_d;
`ifdef BTN_REPEAT_EN
               rc_q      <= rc_d;
`endif
            end
         end

         assign btn_level[gi]   = level_q;
         assign btn_press[gi]   = press_q;
         assign btn_release[gi] = release_q;
      end
   endgenerate

endmodule
